// File: rtl/ntru_hrss_pkg.sv
// Shared NTRU-HRSS-701 constants and types for the Encaps datapath.
package ntru_hrss_pkg;

  localparam int HRSS_N  = 701;
  localparam int COEF_W  = 13;
  localparam int N_PAIRS = 350;
  localparam int IDX_W   = 9;

  typedef logic [COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    TAIL
  } unpack_state_t;

endpackage

// File: rtl/rq_unpack_h_if.sv
// Window-in / coefficient-out bundle between the h register and the multiplier.
interface rq_unpack_h_if;
  import ntru_hrss_pkg::*;

  logic                  load;
  logic [2*COEF_W-1:0]   win;
  logic                  coef_valid;
  logic                  coef_tail;
  coef_t                 coef0;
  coef_t                 coef1;
  logic [IDX_W-1:0]      pair_idx;
  logic                  busy;
  logic                  done;

  modport master (
    output load, win,
    input  coef_valid, coef_tail, coef0, coef1, pair_idx, busy, done
  );

  modport slave (
    input  load, win,
    output coef_valid, coef_tail, coef0, coef1, pair_idx, busy, done
  );

endinterface

// File: rtl/rq_unpack_h.sv
// Streaming unpacker for the packed public key h: splits each 26-bit window
// into two 13-bit Rq coefficients and, when RQ_UNPACK_TAIL_EN is defined,
// reconstructs coefficient 700 as the negated sum of the other 700 mod 8192.
// Without RQ_UNPACK_TAIL_EN the final state only closes the frame with done.
module rq_unpack_h
  import ntru_hrss_pkg::*;
(
  input logic          clk,
  input logic          rst,
  rq_unpack_h_if.slave bus
);

  unpack_state_t    state;
  logic [IDX_W-1:0] cnt;
  logic             coef_valid;
  logic             coef_tail;
  coef_t            coef0;
  coef_t            coef1;
  logic [IDX_W-1:0] pair_idx;
  logic             busy;
  logic             done;
`ifdef RQ_UNPACK_TAIL_EN
  coef_t            acc;
`endif

  coef_t even_coef;
  coef_t odd_coef;

  assign even_coef = bus.win[COEF_W-1:0];
  assign odd_coef  = bus.win[2*COEF_W-1:COEF_W];

  assign bus.coef_valid = coef_valid;
  assign bus.coef_tail  = coef_tail;
  assign bus.coef0      = coef0;
  assign bus.coef1      = coef1;
  assign bus.pair_idx   = pair_idx;
  assign bus.busy       = busy;
  assign bus.done       = done;

  // Unpacker FSM: a load always restarts the key, then one pair per cycle, then the tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      coef_valid <= 1'b0;
      coef_tail  <= 1'b0;
      coef0      <= '0;
      coef1      <= '0;
      pair_idx   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef RQ_UNPACK_TAIL_EN
      acc        <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (bus.load) begin
        state      <= STREAM;
        cnt        <= '0;
        coef_valid <= 1'b0;
        coef_tail  <= 1'b0;
        busy       <= 1'b1;
`ifdef RQ_UNPACK_TAIL_EN
        acc        <= '0;
`endif
      end else begin
        case (state)
          IDLE: begin
            coef_valid <= 1'b0;
            coef_tail  <= 1'b0;
          end
          STREAM: begin
            coef0      <= even_coef;
            coef1      <= odd_coef;
            pair_idx   <= cnt;
            coef_valid <= 1'b1;
            coef_tail  <= 1'b0;
`ifdef RQ_UNPACK_TAIL_EN
            acc        <= acc + even_coef + odd_coef;
`endif
            if (cnt == IDX_W'(N_PAIRS - 1)) begin
              state <= TAIL;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          TAIL: begin
`ifdef RQ_UNPACK_TAIL_EN
            coef0      <= coef_t'(0) - acc;
            coef1      <= '0;
            pair_idx   <= IDX_W'(N_PAIRS);
            coef_valid <= 1'b1;
            coef_tail  <= 1'b1;
`else
            coef_valid <= 1'b0;
            coef_tail  <= 1'b0;
`endif
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            state      <= IDLE;
            coef_valid <= 1'b0;
            coef_tail  <= 1'b0;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rq_unpack_h.sv
// Directed self-checking bench for rq_unpack_h; expectations follow
// RQ_UNPACK_TAIL_EN the same way the design build does.
module tb_rq_unpack_h;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rq_unpack_h_if bus ();

  rq_unpack_h dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Key patterns: 0 all-zero, 1 only coefficient 0 = 1, 2 all 8191, 3 ramp i = i.
  function automatic logic [25:0] win_for(input int mode, input int k);
    logic [12:0] lo;
    logic [12:0] hi;
    lo = 13'd0;
    hi = 13'd0;
    case (mode)
      1: lo = (k == 0) ? 13'd1 : 13'd0;
      2: begin lo = 13'h1fff; hi = 13'h1fff; end
      3: begin lo = 13'(2 * k); hi = 13'(2 * k + 1); end
      default: ;
    endcase
    return {hi, lo};
  endfunction

  // Streams one complete key from load through the cycle after done.
  task automatic run_key(input int mode, input logic [12:0] exp_tail, input string name);
    int          done_cnt;
    int          busy_err;
    logic [37:0] got;
    logic [37:0] exp;
    logic [25:0] w;
    logic [2:0]  got3;
    done_cnt = 0;
    busy_err = 0;
    bus.load = 1'b1;
    bus.win  = '0;
    step();
    bus.load = 1'b0;
    got3 = {bus.busy, bus.done, bus.coef_tail};
    checks++;
    if (got3 !== 3'b100) begin
      failures++;
      $display("[TB] FAIL %s_start: got busy/done/tail=%b expected 100", name, got3);
    end
    for (int k = 0; k < 350; k++) begin
      w = win_for(mode, k);
      bus.win = w;
      step();
      got = {bus.coef_valid, bus.coef_tail, bus.done, bus.pair_idx, bus.coef1, bus.coef0};
      exp = {3'b100, 9'(k), w};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL %s_pair%0d: got %h expected %h", name, k, got, exp);
      end
      if (bus.busy !== 1'b1) busy_err++;
      if (bus.done === 1'b1) done_cnt++;
    end
    bus.win = '0;
    step();
    if (bus.done === 1'b1) done_cnt++;
`ifdef RQ_UNPACK_TAIL_EN
    got = {bus.coef_valid, bus.coef_tail, bus.done, bus.pair_idx, bus.coef1, bus.coef0};
    exp = {3'b111, 9'd350, 13'd0, exp_tail};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s_tail: got %h expected %h", name, got, exp);
    end
`else
    got3 = {bus.coef_valid, bus.coef_tail, bus.done};
    checks++;
    if (got3 !== 3'b001) begin
      failures++;
      $display("[TB] FAIL %s_notail_done: got valid/tail/done=%b expected 001 (tail %0d unused)",
               name, got3, exp_tail);
    end
`endif
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s_busy_end: got %b expected 0", name, bus.busy);
    end
    step();
    if (bus.done === 1'b1) done_cnt++;
    got3 = {bus.coef_valid, bus.coef_tail, bus.done};
    checks++;
    if (got3 !== 3'b000) begin
      failures++;
      $display("[TB] FAIL %s_after: got valid/tail/done=%b expected 000", name, got3);
    end
    checks++;
    if (busy_err !== 0) begin
      failures++;
      $display("[TB] FAIL %s_busy: got %0d low cycles expected 0", name, busy_err);
    end
    checks++;
    if (done_cnt !== 1) begin
      failures++;
      $display("[TB] FAIL %s_done_count: got %0d expected 1", name, done_cnt);
    end
  endtask

  task automatic test_reset();
    logic [39:0] got;
    rst      = 1'b1;
    bus.load = 1'b1;
    bus.win  = '1;
    step();
    step();
    got = {bus.coef_valid, bus.coef_tail, bus.done, bus.busy, bus.pair_idx, bus.coef1, bus.coef0};
    checks++;
    if (got !== 40'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", got);
    end
    bus.load = 1'b0;
    bus.win  = '0;
    rst      = 1'b0;
    step();
  endtask

  task automatic test_zero_key();
    run_key(0, 13'd0, "zero");
  endtask

  task automatic test_single_coef();
    run_key(1, 13'd8191, "single");
  endtask

  task automatic test_all_ones();
    run_key(2, 13'd700, "ones");
  endtask

  task automatic test_ramp();
    run_key(3, 13'd1110, "ramp");
  endtask

  // Ramp key aborted at pair 100 by a fresh load of an all-zero key.
  task automatic test_restart();
    int partial_done;
    partial_done = 0;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    for (int k = 0; k < 100; k++) begin
      bus.win = win_for(3, k);
      step();
      if (bus.done === 1'b1) partial_done++;
    end
    checks++;
    if (partial_done !== 0) begin
      failures++;
      $display("[TB] FAIL restart_early_done: got %0d expected 0", partial_done);
    end
    run_key(0, 13'd0, "restart");
  endtask

  // Load arriving on the same edge as the last pair sample suppresses the tail.
  task automatic test_load_on_last_pair();
    int partial_done;
    partial_done = 0;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    for (int k = 0; k < 349; k++) begin
      bus.win = win_for(2, k);
      step();
      if (bus.done === 1'b1) partial_done++;
    end
    bus.win = win_for(2, 349);
    checks++;
    if (partial_done !== 0) begin
      failures++;
      $display("[TB] FAIL lastpair_early_done: got %0d expected 0", partial_done);
    end
    run_key(1, 13'd8191, "lastpair");
  endtask

  // Reset in the middle of a key clears outputs and never completes it.
  task automatic test_reset_mid_stream();
    logic [39:0] got;
    int          stray;
    stray = 0;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    for (int k = 0; k < 200; k++) begin
      bus.win = win_for(3, k);
      step();
    end
    bus.win = win_for(3, 200);
    rst = 1'b1;
    step();
    rst = 1'b0;
    got = {bus.coef_valid, bus.coef_tail, bus.done, bus.busy, bus.pair_idx, bus.coef1, bus.coef0};
    checks++;
    if (got !== 40'd0) begin
      failures++;
      $display("[TB] FAIL midrst_outputs: got %h expected 0", got);
    end
    for (int c = 0; c < 360; c++) begin
      bus.win = win_for(3, (c + 201) % 350);
      step();
      if (bus.done !== 1'b0 || bus.coef_valid !== 1'b0 || bus.busy !== 1'b0) stray++;
    end
    checks++;
    if (stray !== 0) begin
      failures++;
      $display("[TB] FAIL midrst_no_done: got %0d active cycles expected 0", stray);
    end
  endtask

  // Scenario sequence.
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.load = 1'b0;
    bus.win  = '0;
    test_reset();
    test_zero_key();
    test_single_coef();
    test_all_ones();
    test_ramp();
    test_restart();
    test_load_on_last_pair();
    test_reset_mid_stream();
    test_ramp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
